ctrl_modo_libre: RTL and testbench
==================================

// Module: ctrl_modo_libre
// PURPOSE
// - Scheduler in front of the free-mode typing FSM. Accepts ASCII key codes from the keyboard decoder,
//   filters and buffers them, and presents them to the FSM one at a time with a valid/ready handshake.
// - Sequences the FSM session: issues the start pulse, streams characters, drains on end-of-session.
// - Sits between the keyboard decoder and the free-mode FSM; one instance per free-mode datapath.
// PARAMETERS
// - ANCHO           8  width of a character code, in bits
// - PROF            4  FIFO depth in entries; must be a power of 2, >= 2
// - CICLOS_ARRANQUE 2  number of cycles fsm_inicio is held high at session start (>= 1)
// PORTS
// - clk          in   1      system clock; all state changes on the rising edge
// - reset        in   1      asynchronous, active-low reset
// - inicio       in   1      session start request (level); honoured only in REPOSO
// - fin          in   1      session end request (level); honoured in ESPERA/ENVIO
// - tecla        in   ANCHO  ASCII code from the keyboard decoder
// - tecla_valida in   1      single-cycle strobe; tecla is valid while this is high
// - fsm_listo    in   1      free-mode FSM ready to accept fsm_entrada
// - fsm_inicio   out  1      start pulse to the free-mode FSM
// - fsm_entrada  out  ANCHO  character presented to the FSM; 0 whenever fsm_valido=0
// - fsm_valido   out  1      fsm_entrada valid
// - ocupado      out  1      high in every state except REPOSO
// - lleno        out  1      FIFO holds PROF entries
// - descartes    out  8      count of dropped keys; saturates at 255; cleared on session start
// BEHAVIOUR
// - Reset (reset=0, async): state=REPOSO, FIFO empty, all outputs 0, fin_pend=0, descartes=0.
// - States:
//   REPOSO    wait; inicio=1 -> ARRANQUE. Keys are ignored (not queued, not counted).
//   ARRANQUE  fsm_inicio=1 for exactly CICLOS_ARRANQUE cycles; FIFO flushed and descartes cleared on
//             entry; keys arriving in ARRANQUE are queued. Then -> ESPERA.
//   ESPERA    FIFO non-empty -> ENVIO; FIFO empty and fin_pend=1 -> REPOSO.
//   ENVIO     fsm_valido=1, fsm_entrada=FIFO head, both stable until handshake.
//             Handshake = fsm_valido & fsm_listo at the clock edge: pop the head -> ESPERA.
// - fin=1 in ESPERA/ENVIO sets fin_pend. Keys are still accepted while fin_pend=1; all queued characters
//   are delivered before REPOSO. fin_pend is cleared on entry to REPOSO.
// - Key filter: only codes 0x20..0x7E are pushed. Other codes (e.g. 0x0D, 0x7F) increment descartes.
// - Overflow: a valid key arriving while lleno=1 with no pop in the same cycle is dropped and counted.
// - Push and pop in the same cycle while full: the push is accepted, occupancy stays PROF, no discard.
// - Push into an empty FIFO:
//   - strobe at edge k -> head visible after k, ENVIO entered at edge k+1;
//   - fsm_valido is therefore high from k+1 (2-cycle latency).
// - Order: strictly FIFO. Pointers are log2(PROF) bits, wrap modulo PROF; occupancy counter is log2(PROF)+1 bits.
// - inicio held high across a session has no effect after ARRANQUE; a new session needs a return to REPOSO.
// - Async reset mid-ENVIO: outputs drop immediately, the in-flight character is lost, and no handshake is reported.
// TESTING
// - Reset with reset=0 during ENVIO -> fsm_valido, fsm_entrada, ocupado, lleno and descartes go to 0 without
//   waiting for a clock edge.
// - inicio=1 for 1 cycle -> fsm_inicio high for exactly 2 cycles; then keys 65,66,67,68 with fsm_listo=1
//   -> fsm_entrada delivers 0x41,0x42,0x43,0x44 in order, one handshake each.
// - fsm_listo=0, push 5 keys 'A'..'E' -> lleno=1 after the 4th, descartes=1; then fsm_listo=1
//   -> exactly 'A'..'D' delivered.
// - Keys 0x0D then 0x7F during a session -> descartes=2, fsm_valido stays 0.
// - Queue 'X','Y', assert fin for 1 cycle -> both delivered, then REPOSO with ocupado=0;
//   a further key 'Z' is ignored and descartes is unchanged.
// - FIFO full and fsm_listo=1 and tecla_valida=1 in the same cycle -> lleno stays 1, descartes unchanged,
//   new key delivered last.

Source files
------------

// File: rtl/ctrl_modo_libre.sv
// Scheduler in front of the free-mode typing FSM: filters and queues key codes,
// then hands them to the FSM one at a time over a valid/ready handshake.
module ctrl_modo_libre #(
  parameter int unsigned ANCHO           = 8,
  parameter int unsigned PROF            = 4,
  parameter int unsigned CICLOS_ARRANQUE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inicio,
  input  logic             fin,
  input  logic [ANCHO-1:0] tecla,
  input  logic             tecla_valida,
  input  logic             fsm_listo,
  output logic             fsm_inicio,
  output logic [ANCHO-1:0] fsm_entrada,
  output logic             fsm_valido,
  output logic             ocupado,
  output logic             lleno,
  output logic [7:0]       descartes
);

  localparam int unsigned PW = (PROF > 1) ? $clog2(PROF) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned AW = (CICLOS_ARRANQUE > 1) ? $clog2(CICLOS_ARRANQUE) : 1;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    ARRANQUE = 2'd1,
    ESPERA   = 2'd2,
    ENVIO    = 2'd3
  } estado_t;

  estado_t          estado_q, estado_d;
  logic [ANCHO-1:0] mem_q [PROF];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    arr_q, arr_d;
  logic             fin_pend_q, fin_pend_d;
  logic [7:0]       desc_q, desc_d;
  logic             inicio_q, inicio_d;
  logic             valido_q, valido_d;
  logic [ANCHO-1:0] entrada_q, entrada_d;
  logic             ocupado_q, ocupado_d;
  logic             lleno_q, lleno_d;

  logic activo, tecla_ok, lleno_ahora, pop, push, drop;

  // Next-state, FIFO bookkeeping and registered-output decode
  always_comb begin
    estado_d   = estado_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    arr_d      = arr_q;
    fin_pend_d = fin_pend_q;
    desc_d     = desc_q;

    activo      = (estado_q != REPOSO);
    tecla_ok    = (tecla >= ANCHO'(8'h20)) && (tecla <= ANCHO'(8'h7E));
    lleno_ahora = (cnt_q == CW'(PROF));
    pop         = valido_q & fsm_listo;
    push        = activo & tecla_valida & tecla_ok & (~lleno_ahora | pop);
    drop        = activo & tecla_valida & (~tecla_ok | (lleno_ahora & ~pop));

    if (push) wr_d = wr_q + PW'(1);
    if (pop)  rd_d = rd_q + PW'(1);
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);

    if (drop && (desc_q != 8'hFF)) desc_d = desc_q + 8'd1;
    if (fin && (estado_q == ESPERA || estado_q == ENVIO)) fin_pend_d = 1'b1;

    case (estado_q)
      REPOSO: begin
        if (inicio) begin
          estado_d   = ARRANQUE;
          arr_d      = '0;
          wr_d       = '0;
          rd_d       = '0;
          cnt_d      = '0;
          desc_d     = '0;
          fin_pend_d = 1'b0;
        end
      end
      ARRANQUE: begin
        if (arr_q == AW'(CICLOS_ARRANQUE - 1)) estado_d = ESPERA;
        else                                   arr_d    = arr_q + AW'(1);
      end
      ESPERA: begin
        if (cnt_q != '0) begin
          estado_d = ENVIO;
        end else if (fin_pend_q) begin
          estado_d   = REPOSO;
          fin_pend_d = 1'b0;
        end
      end
      ENVIO: begin
        if (pop) estado_d = ESPERA;
      end
      default: estado_d = REPOSO;
    endcase

    // Head cannot move while entering or holding ENVIO, so rd_q addresses it
    inicio_d  = (estado_d == ARRANQUE);
    valido_d  = (estado_d == ENVIO);
    entrada_d = valido_d ? mem_q[rd_q] : '0;
    ocupado_d = (estado_d != REPOSO);
    lleno_d   = (cnt_d == CW'(PROF));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q   <= REPOSO;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      arr_q      <= '0;
      fin_pend_q <= 1'b0;
      desc_q     <= '0;
      inicio_q   <= 1'b0;
      valido_q   <= 1'b0;
      entrada_q  <= '0;
      ocupado_q  <= 1'b0;
      lleno_q    <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      arr_q      <= arr_d;
      fin_pend_q <= fin_pend_d;
      desc_q     <= desc_d;
      inicio_q   <= inicio_d;
      valido_q   <= valido_d;
      entrada_q  <= entrada_d;
      ocupado_q  <= ocupado_d;
      lleno_q    <= lleno_d;
    end
  end

  // FIFO storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PROF; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_q] <= tecla;
    end
  end

  assign fsm_inicio  = inicio_q;
  assign fsm_valido  = valido_q;
  assign fsm_entrada = entrada_q;
  assign ocupado     = ocupado_q;
  assign lleno       = lleno_q;
  assign descartes   = desc_q;

endmodule

// File: tb/tb_ctrl_modo_libre.sv
// Directed vector bench for ctrl_modo_libre: table of per-cycle stimulus and
// expected outputs, followed by a hand-written async-reset-during-ENVIO sequence.
module tb_ctrl_modo_libre;

  logic       clk, reset;
  logic       inicio, fin, tecla_valida, fsm_listo;
  logic [7:0] tecla;
  logic       fsm_inicio, fsm_valido, ocupado, lleno;
  logic [7:0] fsm_entrada, descartes;

  int n_chk = 0;
  int n_err = 0;

  ctrl_modo_libre #(.ANCHO(8), .PROF(4), .CICLOS_ARRANQUE(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .inicio      (inicio),
    .fin         (fin),
    .tecla       (tecla),
    .tecla_valida(tecla_valida),
    .fsm_listo   (fsm_listo),
    .fsm_inicio  (fsm_inicio),
    .fsm_entrada (fsm_entrada),
    .fsm_valido  (fsm_valido),
    .ocupado     (ocupado),
    .lleno       (lleno),
    .descartes   (descartes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {fsm_inicio, fsm_valido, fsm_entrada, ocupado, lleno, descartes}
  typedef struct packed {
    logic       ini;
    logic       fin;
    logic [7:0] tecla;
    logic       tv;
    logic       listo;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic i, input logic f, input logic [7:0] t,
                              input logic tv, input logic l, input logic ei,
                              input logic ev, input logic [7:0] ee, input logic eo,
                              input logic el, input logic [7:0] ed);
    vec_t v;
    v.ini = i; v.fin = f; v.tecla = t; v.tv = tv; v.listo = l;
    v.exp = {ei, ev, ee, eo, el, ed};
    vecs.push_back(v);
  endfunction

  function automatic logic [19:0] obs();
    return {fsm_inicio, fsm_valido, fsm_entrada, ocupado, lleno, descartes};
  endfunction

  task automatic chk(input string nm, input logic [19:0] act, input logic [19:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got {ini,val,ent,ocu,lle,desc}=%h required %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic i, input logic f, input logic [7:0] t,
                       input logic tv, input logic l);
    inicio = i; fin = f; tecla = t; tecla_valida = tv; fsm_listo = l;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 8'h00, 0, 0);

    // Session start, then A..D streamed with the FSM always ready
    add(1,0,8'h00,0,0, 1,0,8'h00,1,0,8'd0);
    add(0,0,8'h00,0,0, 1,0,8'h00,1,0,8'd0);
    add(0,0,8'h00,0,0, 0,0,8'h00,1,0,8'd0);
    add(0,0,8'h41,1,1, 0,0,8'h00,1,0,8'd0);
    add(0,0,8'h42,1,1, 0,1,8'h41,1,0,8'd0);
    add(0,0,8'h43,1,1, 0,0,8'h00,1,0,8'd0);
    add(0,0,8'h44,1,1, 0,1,8'h42,1,0,8'd0);
    add(0,0,8'h00,0,1, 0,0,8'h00,1,0,8'd0);
    add(0,0,8'h00,0,1, 0,1,8'h43,1,0,8'd0);
    add(0,0,8'h00,0,1, 0,0,8'h00,1,0,8'd0);
    add(0,0,8'h00,0,1, 0,1,8'h44,1,0,8'd0);
    add(0,0,8'h00,0,1, 0,0,8'h00,1,0,8'd0);
    add(0,0,8'h00,0,1, 0,0,8'h00,1,0,8'd0);
    // Filtered codes
    add(0,0,8'h0D,1,1, 0,0,8'h00,1,0,8'd1);
    add(0,0,8'h7F,1,1, 0,0,8'h00,1,0,8'd2);
    add(0,0,8'h00,0,1, 0,0,8'h00,1,0,8'd2);
    // Fill with FSM stalled, overflow E, then push F while popping at full
    add(0,0,8'h41,1,0, 0,0,8'h00,1,0,8'd2);
    add(0,0,8'h42,1,0, 0,1,8'h41,1,0,8'd2);
    add(0,0,8'h43,1,0, 0,1,8'h41,1,0,8'd2);
    add(0,0,8'h44,1,0, 0,1,8'h41,1,1,8'd2);
    add(0,0,8'h45,1,0, 0,1,8'h41,1,1,8'd3);
    add(0,0,8'h46,1,1, 0,0,8'h00,1,1,8'd3);
    add(0,0,8'h00,0,1, 0,1,8'h42,1,1,8'd3);
    add(0,0,8'h00,0,1, 0,0,8'h00,1,0,8'd3);
    add(0,0,8'h00,0,1, 0,1,8'h43,1,0,8'd3);
    add(0,0,8'h00,0,1, 0,0,8'h00,1,0,8'd3);
    add(0,0,8'h00,0,1, 0,1,8'h44,1,0,8'd3);
    add(0,0,8'h00,0,1, 0,0,8'h00,1,0,8'd3);
    add(0,0,8'h00,0,1, 0,1,8'h46,1,0,8'd3);
    add(0,0,8'h00,0,1, 0,0,8'h00,1,0,8'd3);
    // X, Y queued, fin pulse, drain to REPOSO, then Z ignored
    add(0,0,8'h58,1,0, 0,0,8'h00,1,0,8'd3);
    add(0,1,8'h59,1,0, 0,1,8'h58,1,0,8'd3);
    add(0,0,8'h00,0,1, 0,0,8'h00,1,0,8'd3);
    add(0,0,8'h00,0,1, 0,1,8'h59,1,0,8'd3);
    add(0,0,8'h00,0,1, 0,0,8'h00,1,0,8'd3);
    add(0,0,8'h00,0,1, 0,0,8'h00,0,0,8'd3);
    add(0,0,8'h5A,1,1, 0,0,8'h00,0,0,8'd3);
    add(0,0,8'h00,0,1, 0,0,8'h00,0,0,8'd3);

    repeat (3) tick();
    chk("reset_state", obs(), 20'h0);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ini, vecs[i].fin, vecs[i].tecla, vecs[i].tv, vecs[i].listo);
      tick();
      chk($sformatf("vec%0d", i), obs(), vecs[i].exp);
    end
    drive(0, 0, 8'h00, 0, 0);

    // New session clears descartes; fill the FIFO, then reset asynchronously in ENVIO
    drive(1, 0, 8'h00, 0, 0);
    tick();
    chk("restart_clears_desc", obs(), {1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'd0});
    drive(0, 0, 8'h0D, 1, 0);
    tick();
    for (int c = 8'h41; c <= 8'h44; c++) begin
      drive(0, 0, 8'(c), 1, 0);
      tick();
    end
    drive(0, 0, 8'h00, 0, 0);
    chk("full_in_envio", obs(), {1'b0, 1'b1, 8'h41, 1'b1, 1'b1, 8'd1});
    #2 reset = 1'b0;
    #1 chk("async_reset_no_edge", obs(), 20'h0);
    tick();
    reset = 1'b1;
    drive(0, 0, 8'h00, 0, 1);
    repeat (3) tick();
    chk("idle_after_reset", obs(), 20'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
